regfile_multiport_sync: RTL and testbench



---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_read_port.sv | 53 +++++
 rtl/regfile_multiport_sync.sv | 95 +++++++++
 tb/tb_regfile_multiport_sync.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the multiport register file.
// Optional write-to-read forwarding is enabled with `define REGFILE_BYPASS_EN.
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 5;
    localparam int DEFAULT_NUM_READ   = 2;

    // Index of the hardwired-zero register.
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: address mux, register-0 forcing and, when
// REGFILE_BYPASS_EN is defined, same-edge write forwarding.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  ctrl_reset_n,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0] storage [DEPTH],
    input  logic                  write_accept,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data
);

    logic [DATA_WIDTH-1:0] read_next;
    logic                  bypass_hit;

`ifdef REGFILE_BYPASS_EN
    // write_accept already excludes address 0 and writes dropped during a sweep.
    assign bypass_hit = write_accept && (write_addr == read_addr);
`else
    logic unused_bypass;
    assign unused_bypass = ^{write_accept, write_addr, write_data};
    assign bypass_hit    = 1'b0;
`endif

    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        read_next = storage[read_addr];
        if (read_addr == ADDR_WIDTH'(REG_ZERO)) begin
            read_next = '0;
        end else if (bypass_hit) begin
            read_next = write_data;
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            read_data <= '0;
        end else begin
            read_data <= read_next;
        end
    end

endmodule

// File: rtl/regfile_multiport_sync.sv
// Register file: one write port, NUM_READ registered read ports, r0 hardwired
// to zero, sequential bulk-clear sweep. Bypass via `define REGFILE_BYPASS_EN.
module regfile_multiport_sync
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int NUM_READ   = DEFAULT_NUM_READ
) (
    input  logic                           clock,
    input  logic                           ctrl_reset_n,
    input  logic                           ctrl_write_enable,
    input  logic [ADDR_WIDTH-1:0]          ctrl_write_reg,
    input  logic [DATA_WIDTH-1:0]          data_write_reg,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] ctrl_read_regs,
    output logic [NUM_READ*DATA_WIDTH-1:0] data_read_regs,
    input  logic                           ctrl_clear,
    output logic                           clear_busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_REG = ADDR_WIDTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] storage [DEPTH];
    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] counter, counter_next;
    logic                  write_accept;

    assign write_accept = ctrl_write_enable && (state == IDLE) &&
                          (ctrl_write_reg != ADDR_WIDTH'(REG_ZERO));
    assign clear_busy   = (state == CLEAR);

    always_comb begin
        state_next   = state;
        counter_next = counter;
        unique case (state)
            IDLE: begin
                if (ctrl_clear) begin
                    state_next   = CLEAR;
                    counter_next = ADDR_WIDTH'(1);
                end
            end
            CLEAR: begin
                if (counter == LAST_REG) begin
                    state_next   = IDLE;
                    counter_next = '0;
                end else begin
                    counter_next = counter + ADDR_WIDTH'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state   <= IDLE;
            counter <= '0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
        end
    end

    // NOTE: the array sits in the async reset branch because reset must zero
    // every register; this makes it flops rather than an inferred RAM macro.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
        end else if (write_accept) begin
            storage[ctrl_write_reg] <= data_write_reg;
        end else if (state == CLEAR) begin
            storage[counter] <= '0;
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_read
        regfile_read_port #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH),
            .DEPTH     (DEPTH)
        ) u_port (
            .clock       (clock),
            .ctrl_reset_n(ctrl_reset_n),
            .read_addr   (ctrl_read_regs[k*ADDR_WIDTH +: ADDR_WIDTH]),
            .storage     (storage),
            .write_accept(write_accept),
            .write_addr  (ctrl_write_reg),
            .write_data  (data_write_reg),
            .read_data   (data_read_regs[k*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_regfile_multiport_sync.sv
// Randomised self-checking bench: a default 32x32/2-port instance against an
// array model, plus a 8x16/4-port instance for cross-port independence.
module tb_regfile_multiport_sync;

    localparam int DW = 32, AW = 5, NR = 2, DEPTH = 32;
    localparam int SDW = 16, SAW = 3, SNR = 4, SDEPTH = 8;

    logic clock = 1'b0;
    logic ctrl_reset_n = 1'b0;
    always #5 clock = ~clock;

    logic           ctrl_write_enable = 1'b0;
    logic [AW-1:0]  ctrl_write_reg = '0;
    logic [DW-1:0]  data_write_reg = '0;
    logic [NR*AW-1:0] ctrl_read_regs = '0;
    logic [NR*DW-1:0] data_read_regs;
    logic           ctrl_clear = 1'b0;
    logic           clear_busy;

    logic            s_we = 1'b0;
    logic [SAW-1:0]  s_wa = '0;
    logic [SDW-1:0]  s_wd = '0;
    logic [SNR*SAW-1:0] s_ra = '0;
    logic [SNR*SDW-1:0] s_rd;
    logic            s_clr = 1'b0;
    logic            s_busy;

    regfile_multiport_sync #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) dut (
        .clock            (clock),
        .ctrl_reset_n     (ctrl_reset_n),
        .ctrl_write_enable(ctrl_write_enable),
        .ctrl_write_reg   (ctrl_write_reg),
        .data_write_reg   (data_write_reg),
        .ctrl_read_regs   (ctrl_read_regs),
        .data_read_regs   (data_read_regs),
        .ctrl_clear       (ctrl_clear),
        .clear_busy       (clear_busy)
    );

    regfile_multiport_sync #(.DATA_WIDTH(SDW), .ADDR_WIDTH(SAW), .NUM_READ(SNR)) dut_small (
        .clock            (clock),
        .ctrl_reset_n     (ctrl_reset_n),
        .ctrl_write_enable(s_we),
        .ctrl_write_reg   (s_wa),
        .data_write_reg   (s_wd),
        .ctrl_read_regs   (s_ra),
        .data_read_regs   (s_rd),
        .ctrl_clear       (s_clr),
        .clear_busy       (s_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference model: register contents plus the number of sweep edges left.
    logic [DW-1:0]  mem [DEPTH];
    logic [SDW-1:0] smem [SDEPTH];
    int busy_left = 0;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        for (int i = 0; i < SDEPTH; i++) smem[i] = '0;
        busy_left = 0;
    endtask

    // Predict one edge of the main instance, clock it, then compare.
    task automatic tick();
        logic [DW-1:0] exp_rd [NR];
        logic [AW-1:0] ra;
        logic accept;
        accept = (busy_left == 0) && ctrl_write_enable && (ctrl_write_reg != 0);
        for (int k = 0; k < NR; k++) begin
            ra = ctrl_read_regs[k*AW +: AW];
            if (ra == 0) exp_rd[k] = '0;
`ifdef REGFILE_BYPASS_EN
            else if (accept && ra == ctrl_write_reg) exp_rd[k] = data_write_reg;
`endif
            else exp_rd[k] = mem[ra];
        end
        if (busy_left > 0) begin
            mem[DEPTH - busy_left] = '0;
            busy_left--;
        end else begin
            if (accept) mem[ctrl_write_reg] = data_write_reg;
            if (ctrl_clear) busy_left = DEPTH - 1;
        end
        // Small instance: writes only land in the model; it never sweeps.
        if (s_we && s_wa != 0) smem[s_wa] = s_wd;
        @(posedge clock);
        #1;
        for (int k = 0; k < NR; k++)
            check($sformatf("rd%0d", k), 64'(data_read_regs[k*DW +: DW]), 64'(exp_rd[k]));
        check("busy", 64'(clear_busy), 64'(busy_left > 0));
    endtask

    task automatic set_read(input int p, input int a);
        ctrl_read_regs[p*AW +: AW] = AW'(a);
    endtask

    task automatic write_reg(input int a, input logic [DW-1:0] d);
        ctrl_write_enable = 1'b1;
        ctrl_write_reg    = AW'(a);
        data_write_reg    = d;
        tick();
        ctrl_write_enable = 1'b0;
    endtask

    int n;

    initial begin
        model_reset();
        #12;
        check("reset_rd", 64'(data_read_regs), 64'd0);
        check("reset_busy", 64'(clear_busy), 64'd0);
        check("reset_small_rd", s_rd, 64'd0);
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Write r5, read it back on port0 while port1 reads r0.
        write_reg(5, 32'hDEADBEEF);
        set_read(0, 5);
        set_read(1, 0);
        tick();
        check("r5_read", 64'(data_read_regs[0 +: DW]), 64'hDEADBEEF);
        check("r0_read", 64'(data_read_regs[DW +: DW]), 64'd0);

        // Writes to r0 are discarded.
        write_reg(0, 32'hFFFFFFFF);
        set_read(0, 0);
        set_read(1, 0);
        tick();
        check("r0_after_write", 64'(data_read_regs), 64'd0);

        // Same-edge read and write of r7.
        write_reg(7, 32'h1);
        set_read(0, 7);
        ctrl_write_enable = 1'b1;
        ctrl_write_reg    = AW'(7);
        data_write_reg    = 32'h12345678;
        tick();
        ctrl_write_enable = 1'b0;
`ifdef REGFILE_BYPASS_EN
        check("same_edge_r7", 64'(data_read_regs[0 +: DW]), 64'h12345678);
`else
        check("same_edge_r7", 64'(data_read_regs[0 +: DW]), 64'h1);
`endif

        // Fill r1..r31 with their index, then sweep.
        for (int i = 1; i < DEPTH; i++) write_reg(i, DW'(i));
        ctrl_clear = 1'b1;
        tick();
        ctrl_clear = 1'b0;
        n = 0;
        while (clear_busy && n < 100) begin
            n++;
            if (n == 10) begin
                set_read(0, 3);
                set_read(1, 30);
            end
            if (n == 12) begin
                ctrl_write_enable = 1'b1;
                ctrl_write_reg    = AW'(10);
                data_write_reg    = 32'hCAFE0010;
                set_read(0, 10);
            end
            tick();
            ctrl_write_enable = 1'b0;
            if (n == 10) begin
                check("mid_sweep_r3", 64'(data_read_regs[0 +: DW]), 64'd0);
                check("mid_sweep_r30", 64'(data_read_regs[DW +: DW]), 64'd30);
            end
        end
        check("sweep_cycles", 64'(n), 64'd31);
        for (int i = 0; i < DEPTH; i += 2) begin
            set_read(0, i);
            set_read(1, i + 1);
            tick();
            check("post_sweep_pair", 64'(data_read_regs), 64'd0);
        end

        // Randomised traffic with occasional sweeps.
        for (int c = 0; c < 400; c++) begin
            ctrl_write_enable = 1'($urandom_range(0, 1));
            ctrl_write_reg    = AW'($urandom);
            data_write_reg    = DW'($urandom);
            ctrl_read_regs    = (NR*AW)'($urandom);
            ctrl_clear        = ($urandom_range(0, 79) == 0);
            if (c % 7 == 0) ctrl_read_regs[AW-1:0] = ctrl_write_reg;
            tick();
        end
        ctrl_write_enable = 1'b0;
        ctrl_clear = 1'b0;
        n = 0;
        while (clear_busy && n < 100) begin
            n++;
            tick();
        end
        check("random_sweep_done", 64'(clear_busy), 64'd0);

        // Asynchronous reset ten cycles into a sweep.
        for (int i = 1; i < DEPTH; i++) write_reg(i, DW'($urandom) | 32'h1);
        set_read(0, 20);
        set_read(1, 31);
        ctrl_clear = 1'b1;
        tick();
        ctrl_clear = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("pre_reset_rd_nonzero", 64'(data_read_regs != 0), 64'd1);
        #2;
        ctrl_reset_n = 1'b0;
        #1;
        check("async_reset_busy", 64'(clear_busy), 64'd0);
        check("async_reset_rd", 64'(data_read_regs), 64'd0);
        model_reset();
        #1;
        ctrl_reset_n = 1'b1;
        ctrl_clear = 1'b1;
        tick();
        ctrl_clear = 1'b0;
        n = 0;
        while (clear_busy && n < 100) begin
            n++;
            tick();
        end
        check("restart_sweep_cycles", 64'(n), 64'd31);

        // Four-port, 8x16 instance: distinct simultaneous reads.
        for (int i = 1; i < SDEPTH; i++) begin
            s_we = 1'b1;
            s_wa = SAW'(i);
            s_wd = SDW'(16'h00A0 + i);
            tick();
        end
        s_we = 1'b0;
        s_ra = {3'd7, 3'd5, 3'd3, 3'd1};
        tick();
        for (int k = 0; k < SNR; k++)
            check($sformatf("small_port%0d", k), 64'(s_rd[k*SDW +: SDW]), 64'(16'h00A0 + 2*k + 1));
        for (int c = 0; c < 30; c++) begin
            logic [SAW-1:0] a [SNR];
            for (int k = 0; k < SNR; k++) begin
                a[k] = SAW'($urandom);
                s_ra[k*SAW +: SAW] = a[k];
            end
            tick();
            for (int k = 0; k < SNR; k++)
                check($sformatf("small_rand%0d", k), 64'(s_rd[k*SDW +: SDW]),
                      64'((a[k] == 0) ? 16'h0 : smem[a[k]]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
